// File: rtl/program_loader_if.sv
// Byte-stream in / memory-write out bundle for the program loader.
// slave = the loader itself, master = the byte source and memory side.
interface program_loader_if #(
  parameter int DataWidth = 16,
  parameter int AddrWidth = 8
);
  logic [7:0]           Rx_Data;
  logic                 Rx_Valid;
  logic                 Rx_Ready;
  logic [AddrWidth-1:0] Mem_Addr;
  logic [DataWidth-1:0] Mem_Data;
  logic                 Mem_Wr;
  logic                 CPU_Hold;
  logic                 Done;
  logic                 Err;

  modport slave (
    input  Rx_Data, Rx_Valid,
    output Rx_Ready, Mem_Addr, Mem_Data, Mem_Wr, CPU_Hold, Done, Err
  );

  modport master (
    output Rx_Data, Rx_Valid,
    input  Rx_Ready, Mem_Addr, Mem_Data, Mem_Wr, CPU_Hold, Done, Err
  );
endinterface

// File: rtl/program_loader.sv
// Frame-driven program memory writer: SYNC, ADDR, COUNT, COUNT words (MSB first), CHK.
// Holds the CPU in reset while a frame loads; words are written with a one-cycle strobe.
module program_loader #(
  parameter int         DataWidth     = 16,
  parameter int         AddrWidth     = 8,
  parameter logic [7:0] SyncByte      = 8'hA5,
  parameter int         TimeoutCycles = 1024
) (
  input  logic            Clk,
  input  logic            Reset,
  program_loader_if.slave bus
);
  localparam int BPW = DataWidth / 8;
  localparam int BW  = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int IW  = $clog2(TimeoutCycles + 1);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_COUNT, S_DATA, S_WRITE, S_CHK} state_t;

  state_t               state;
  logic                 rx_ready;
  logic [AddrWidth-1:0] addr, mem_addr;
  logic [DataWidth-1:0] word, mem_data;
  logic [7:0]           cnt, sum;
  logic [BW-1:0]        bidx;
  logic [IW-1:0]        idle;
  logic                 mem_wr, cpu_hold, done, err;

  logic                 acc;
  logic [DataWidth-1:0] word_nxt;
  logic [7:0]           sum_nxt;
  logic                 in_frame;

  always_comb begin
    acc      = bus.Rx_Valid & rx_ready;
    word_nxt = (word << 8) | DataWidth'(bus.Rx_Data);
    sum_nxt  = sum + bus.Rx_Data;
    in_frame = (state == S_ADDR) || (state == S_COUNT) || (state == S_DATA) || (state == S_CHK);
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state    <= S_IDLE;
      rx_ready <= 1'b1;
      addr     <= '0;
      mem_addr <= '0;
      word     <= '0;
      mem_data <= '0;
      cnt      <= '0;
      sum      <= '0;
      bidx     <= '0;
      idle     <= '0;
      mem_wr   <= 1'b0;
      cpu_hold <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      mem_wr <= 1'b0;
      done   <= 1'b0;
      case (state)
        S_IDLE: if (acc && bus.Rx_Data == SyncByte) begin
          state    <= S_ADDR;
          cpu_hold <= 1'b1;
          err      <= 1'b0;
          sum      <= '0;
          idle     <= '0;
        end
        S_ADDR: if (acc) begin
          addr  <= bus.Rx_Data[AddrWidth-1:0];
          sum   <= sum_nxt;
          idle  <= '0;
          state <= S_COUNT;
        end
        S_COUNT: if (acc) begin
          cnt   <= bus.Rx_Data;
          sum   <= sum_nxt;
          idle  <= '0;
          bidx  <= '0;
          state <= (bus.Rx_Data == 8'd0) ? S_CHK : S_DATA;
        end
        S_DATA: if (acc) begin
          sum  <= sum_nxt;
          idle <= '0;
          word <= word_nxt;
          // Last byte of the word: present the write on this same edge so the
          // strobe lands in the cycle right after the byte is accepted.
          if (bidx == BW'(BPW - 1)) begin
            mem_addr <= addr;
            mem_data <= word_nxt;
            mem_wr   <= 1'b1;
            rx_ready <= 1'b0;
            state    <= S_WRITE;
          end else begin
            bidx <= bidx + 1'b1;
          end
        end
        S_WRITE: begin
          addr     <= addr + 1'b1;
          cnt      <= cnt - 8'd1;
          bidx     <= '0;
          idle     <= '0;
          rx_ready <= 1'b1;
          state    <= (cnt == 8'd1) ? S_CHK : S_DATA;
        end
        S_CHK: if (acc) begin
          if (sum_nxt == 8'd0) done <= 1'b1;
          else                 err  <= 1'b1;
          sum      <= sum_nxt;
          idle     <= '0;
          cpu_hold <= 1'b0;
          state    <= S_IDLE;
        end
        default: begin
          state    <= S_IDLE;
          rx_ready <= 1'b1;
          cpu_hold <= 1'b0;
        end
      endcase

      // Inter-byte watchdog; only reachable when no byte moved this cycle.
      if (in_frame && !acc) begin
        if (idle == IW'(TimeoutCycles - 1)) begin
          err      <= 1'b1;
          cpu_hold <= 1'b0;
          idle     <= '0;
          state    <= S_IDLE;
        end else begin
          idle <= idle + 1'b1;
        end
      end
    end
  end

  assign bus.Rx_Ready = rx_ready;
  assign bus.Mem_Addr = mem_addr;
  assign bus.Mem_Data = mem_data;
  assign bus.Mem_Wr   = mem_wr;
  assign bus.CPU_Hold = cpu_hold;
  assign bus.Done     = done;
  assign bus.Err      = err;
endmodule

// File: tb/tb_program_loader.sv
// Randomized frame bench for program_loader against a frame-level reference model.
module tb_program_loader;
  localparam int DW = 16;
  localparam int AW = 8;
  localparam int TO = 1024;

  typedef logic [7:0] bq_t[$];

  logic Clk = 1'b0;
  logic Reset = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;

  program_loader_if #(.DataWidth(DW), .AddrWidth(AW)) bus();

  program_loader #(
    .DataWidth(DW), .AddrWidth(AW), .SyncByte(8'hA5), .TimeoutCycles(TO)
  ) dut (
    .Clk(Clk),
    .Reset(Reset),
    .bus(bus)
  );

  always #5 Clk = ~Clk;

  // Write log and protocol invariants, sampled mid-cycle.
  logic [AW+DW-1:0] wr_q[$];
  int done_cnt = 0;
  int inv_bad = 0;
  always @(negedge Clk) if (Reset) begin
    if (bus.Mem_Wr) wr_q.push_back({bus.Mem_Addr, bus.Mem_Data});
    if (bus.Done) done_cnt++;
    if (bus.Rx_Ready == bus.Mem_Wr) inv_bad++;
    if (bus.Done && bus.Err) inv_bad++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: expected writes and checksum verdict straight from the frame bytes.
  logic [AW+DW-1:0] exp_wr[$];
  bit exp_ok;
  function automatic void model(input bq_t fr);
    logic [7:0] s;
    int n;
    exp_wr.delete();
    s = 8'd0;
    for (int i = 1; i < fr.size(); i++) s += fr[i];
    n = fr[2];
    for (int k = 0; k < n; k++) exp_wr.push_back({8'(fr[1] + k), fr[3+2*k], fr[4+2*k]});
    exp_ok = (s == 8'd0);
  endfunction

  function automatic bq_t make_frame(input logic [7:0] a, input logic [7:0] n, input bit good);
    bq_t fr;
    logic [7:0] s, b;
    fr = {8'hA5, a, n};
    s = a + n;
    for (int i = 0; i < 2 * n; i++) begin
      b = 8'($urandom_range(0, 255));
      fr.push_back(b);
      s += b;
    end
    b = 8'd0 - s;
    if (!good) b = b + 8'($urandom_range(1, 255));
    fr.push_back(b);
    return fr;
  endfunction

  task automatic send(input logic [7:0] b);
    int w;
    w = 0;
    @(negedge Clk);
    bus.Rx_Data = b;
    bus.Rx_Valid = 1'b1;
    while (!bus.Rx_Ready && w < 8) begin
      @(negedge Clk);
      w++;
    end
    if (w >= 8) chk("rdy_wait", 32'(bus.Rx_Ready), 1);
    @(posedge Clk);
    #1;
  endtask

  task automatic gap(input int n);
    if (n > 0) begin
      @(negedge Clk);
      bus.Rx_Valid = 1'b0;
      repeat (n - 1) @(negedge Clk);
    end
  endtask

  task automatic run_frame(input bq_t fr, input int maxgap);
    int w0, d0, hb, last;
    model(fr);
    w0 = wr_q.size();
    d0 = done_cnt;
    hb = 0;
    last = fr.size() - 1;
    for (int i = 0; i <= last; i++) begin
      if (maxgap > 0) gap($urandom_range(0, maxgap));
      send(fr[i]);
      if (i == 0) chk("err_clear_on_sync", 32'(bus.Err), 0);
      if (i < last && !bus.CPU_Hold) hb++;
      if (i >= 4 && i < last && ((i - 4) % 2) == 0) begin
        chk("wr_strobe", 32'(bus.Mem_Wr), 1);
        chk("wr_ready_low", 32'(bus.Rx_Ready), 0);
        chk("wr_word", 32'({bus.Mem_Addr, bus.Mem_Data}), 32'(exp_wr[(i-4)/2]));
      end
    end
    chk("hold_in_frame", hb, 0);
    gap(3);
    chk("n_writes", wr_q.size() - w0, exp_wr.size());
    for (int k = 0; k < exp_wr.size(); k++)
      if (w0 + k < wr_q.size()) chk("wr_log", 32'(wr_q[w0+k]), 32'(exp_wr[k]));
    chk("done_pulses", done_cnt - d0, exp_ok ? 1 : 0);
    chk("err", 32'(bus.Err), exp_ok ? 0 : 1);
    chk("hold_end", 32'(bus.CPU_Hold), 0);
  endtask

  initial begin
    bq_t fr;
    int w0;
    logic [7:0] g;
    bus.Rx_Valid = 1'b0;
    bus.Rx_Data = 8'd0;
    #3 Reset = 1'b0;
    repeat (2) @(negedge Clk);
    chk("rst_ready", 32'(bus.Rx_Ready), 1);
    chk("rst_addr", 32'(bus.Mem_Addr), 0);
    chk("rst_data", 32'(bus.Mem_Data), 0);
    chk("rst_wr", 32'(bus.Mem_Wr), 0);
    chk("rst_hold", 32'(bus.CPU_Hold), 0);
    chk("rst_done", 32'(bus.Done), 0);
    chk("rst_err", 32'(bus.Err), 0);
    Reset = 1'b1;

    // Two-word load at 0x10; checksum byte chosen so ADDR..CHK sums to zero.
    fr = {8'hA5, 8'h10, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h30};
    run_frame(fr, 1);
    chk("t1_exp_ok", 32'(exp_ok), 1);

    fr = {8'hA5, 8'h10, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h31};
    run_frame(fr, 0);
    gap(5);
    chk("err_sticky", 32'(bus.Err), 1);

    // Address wrap from 0xFF to 0x00.
    fr = {8'hA5, 8'hFF, 8'h02, 8'h00, 8'h01, 8'h00, 8'h02, 8'hFC};
    run_frame(fr, 2);

    // Stall after ADDR until the watchdog fires.
    w0 = wr_q.size();
    send(8'hA5);
    send(8'h20);
    bus.Rx_Valid = 1'b0;
    repeat (TO - 1) @(posedge Clk);
    #1;
    chk("to_err_early", 32'(bus.Err), 0);
    chk("to_hold_early", 32'(bus.CPU_Hold), 1);
    @(posedge Clk);
    #1;
    chk("to_err", 32'(bus.Err), 1);
    chk("to_hold", 32'(bus.CPU_Hold), 0);
    chk("to_no_writes", wr_q.size() - w0, 0);
    run_frame(make_frame(8'h40, 8'd3, 1'b1), 1);

    // Back-to-back bytes with valid held high throughout.
    for (int f = 0; f < 3; f++)
      run_frame(make_frame(8'($urandom_range(0, 255)), 8'($urandom_range(1, 6)), 1'b1), 0);

    // Reset in the middle of a word.
    w0 = wr_q.size();
    send(8'hA5);
    send(8'h30);
    send(8'h02);
    send(8'h11);
    Reset = 1'b0;
    bus.Rx_Valid = 1'b0;
    #1;
    chk("mid_rst_hold", 32'(bus.CPU_Hold), 0);
    chk("mid_rst_ready", 32'(bus.Rx_Ready), 1);
    chk("mid_rst_addr", 32'(bus.Mem_Addr), 0);
    chk("mid_rst_data", 32'(bus.Mem_Data), 0);
    chk("mid_rst_wr", 32'(bus.Mem_Wr), 0);
    repeat (2) @(negedge Clk);
    Reset = 1'b1;
    repeat (3) @(negedge Clk);
    chk("mid_rst_no_wr", wr_q.size() - w0, 0);
    run_frame(make_frame(8'h30, 8'd2, 1'b1), 1);

    // Random frames, some with bad checksums and leading junk bytes.
    for (int f = 0; f < 12; f++) begin
      repeat ($urandom_range(0, 2)) begin
        g = 8'($urandom_range(0, 255));
        if (g == 8'hA5) g = 8'h00;
        send(g);
      end
      run_frame(make_frame(8'($urandom_range(0, 255)), 8'($urandom_range(0, 5)),
                           $urandom_range(0, 3) != 0), $urandom_range(0, 2));
    end

    chk("invariants", inv_bad, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
